// File: rtl/pipeadder_result_collector.sv
// Result collector for the 4-bit pipelined adder: FIFO of {co,s} words with valid/ready output and running sum.
// Optional feature macro: PIPEADDER_COLLECT_PARITY_EN adds out_parity (XOR of out_data, stored per entry).
module pipeadder_result_collector #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ACC_W  = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      s,
    input  logic                   co,
    input  logic                   clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W:0]        out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [ACC_W-1:0]       acc,
    output logic                   overflow
`ifdef PIPEADDER_COLLECT_PARITY_EN
    ,
    output logic                   out_parity
`endif
);

    localparam int unsigned WORD_W = DATA_W + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr_nxt;
    logic [PTR_W-1:0]  rptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] head_nxt;
    logic [ACC_W-1:0]  acc_nxt;
    logic              ovf_nxt;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

`ifdef PIPEADDER_COLLECT_PARITY_EN
    logic              par_mem [DEPTH];
    logic              par;
    logic              par_nxt;
`endif

    // Handshake decode and next-state of pointers, occupancy and accumulator
    always_comb begin
        word      = {co, s};
        full      = (count == CNT_W'(DEPTH));
        pop       = out_valid & out_ready;
        push      = in_valid & (~full | pop);
        drop      = in_valid & full & ~pop;
        wptr_nxt  = push ? wptr + PTR_W'(1) : wptr;
        rptr_nxt  = pop  ? rptr + PTR_W'(1) : rptr;
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        acc_nxt = acc;
        ovf_nxt = overflow;
        if (clr) begin
            acc_nxt = push ? ACC_W'(word) : '0;
            ovf_nxt = 1'b0;
        end else if (push) begin
            acc_nxt = acc + ACC_W'(word);
        end
        if (drop) begin
            ovf_nxt = 1'b1;
        end
    end

    // Next head word: the incoming word bypasses storage only when it lands exactly at the new read pointer
    always_comb begin
        head_nxt = '0;
        if (count_nxt != '0) begin
            head_nxt = (push && (wptr == rptr_nxt)) ? word : mem[rptr_nxt];
        end
    end

`ifdef PIPEADDER_COLLECT_PARITY_EN
    always_comb begin
        par     = ^word;
        par_nxt = 1'b0;
        if (count_nxt != '0) begin
            par_nxt = (push && (wptr == rptr_nxt)) ? par : par_mem[rptr_nxt];
        end
    end
`endif

    // Storage has no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wptr] <= word;
`ifdef PIPEADDER_COLLECT_PARITY_EN
            par_mem[wptr] <= par;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            overflow  <= 1'b0;
`ifdef PIPEADDER_COLLECT_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            out_data  <= head_nxt;
            acc       <= acc_nxt;
            overflow  <= ovf_nxt;
`ifdef PIPEADDER_COLLECT_PARITY_EN
            out_parity <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pipeadder_result_collector.sv
// Self-checking bench for pipeadder_result_collector: vector table plus queue scoreboard for output ordering.
module tb_pipeadder_result_collector;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ACC_W  = 12;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   in_valid;
    logic [DATA_W-1:0]      s;
    logic                   co;
    logic                   clr;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W:0]        out_data;
    logic [$clog2(DEPTH):0] count;
    logic [ACC_W-1:0]       acc;
    logic                   overflow;
`ifdef PIPEADDER_COLLECT_PARITY_EN
    logic                   out_parity;
`endif

    always #5 clk = ~clk;

    pipeadder_result_collector #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .s        (s),
        .co       (co),
        .clr      (clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .acc      (acc),
        .overflow (overflow)
`ifdef PIPEADDER_COLLECT_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    typedef struct {
        logic       iv;
        logic [4:0] w;
        logic       rdy;
        logic       cl;
        int         ecnt;
        int         eacc;
        logic       eovf;
        logic       evld;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] sb[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic iv, input int w, input logic rdy, input logic cl,
                                input int ecnt, input int eacc, input logic eovf, input logic evld);
        vec_t v;
        v.iv = iv; v.w = 5'(w); v.rdy = rdy; v.cl = cl;
        v.ecnt = ecnt; v.eacc = eacc; v.eovf = eovf; v.evld = evld;
        tbl.push_back(v);
    endfunction

    // One clock: check head against scoreboard, update scoreboard, apply edge
    task automatic cyc(input logic iv, input logic [4:0] w, input logic rdy, input logic cl);
        logic popm;
        logic pushm;
        in_valid  = iv;
        {co, s}   = w;
        out_ready = rdy;
        clr       = cl;
        if (sb.size() > 0) begin
            chk("head_data", int'(out_data), int'(sb[0]));
`ifdef PIPEADDER_COLLECT_PARITY_EN
            chk("head_parity", int'(out_parity), int'(^sb[0]));
`endif
        end
        popm  = (sb.size() > 0) && rdy;
        pushm = iv && ((sb.size() < DEPTH) || popm);
        if (popm) void'(sb.pop_front());
        if (pushm) sb.push_back(w);
        @(posedge clk);
        #1;
        chk("valid_vs_sb", int'(out_valid), int'(sb.size() != 0));
        chk("count_vs_sb", int'(count), sb.size());
    endtask

    initial begin
        int exp_acc;
        rstn = 1'b0; in_valid = 1'b0; s = '0; co = 1'b0; clr = 1'b0; out_ready = 1'b0;

        // Fill, drop, drain
        add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 30, 0, 0, 2, 30, 0, 1);
        add(1, 21, 0, 0, 3, 51, 0, 1);
        add(1, 13, 0, 0, 4, 64, 0, 1);
        add(1, 11, 0, 0, 4, 64, 1, 1);
        add(0, 0, 1, 0, 3, 64, 1, 1);
        add(0, 0, 1, 0, 2, 64, 1, 1);
        add(0, 0, 1, 0, 1, 64, 1, 1);
        add(0, 0, 1, 0, 0, 64, 1, 0);
        add(0, 0, 1, 0, 0, 64, 1, 0);
        // Full with simultaneous push+pop, write pointer wrapping
        add(1, 1, 0, 0, 1, 65, 1, 1);
        add(1, 2, 0, 0, 2, 67, 1, 1);
        add(1, 3, 0, 0, 3, 70, 1, 1);
        add(1, 4, 0, 0, 4, 74, 1, 1);
        add(1, 17, 1, 0, 4, 91, 1, 1);
        add(1, 5, 1, 0, 4, 96, 1, 1);
        add(1, 6, 1, 0, 4, 102, 1, 1);
        add(0, 0, 1, 0, 3, 102, 1, 1);
        add(0, 0, 1, 0, 2, 102, 1, 1);
        add(0, 0, 1, 0, 1, 102, 1, 1);
        add(0, 0, 1, 0, 0, 102, 1, 0);
        // clr with push, clr alone, clr with drop
        add(1, 9, 0, 1, 1, 9, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 1);
        add(1, 1, 0, 0, 2, 1, 0, 1);
        add(1, 2, 0, 0, 3, 3, 0, 1);
        add(1, 3, 0, 0, 4, 6, 0, 1);
        add(1, 7, 0, 1, 4, 0, 1, 1);
        add(0, 0, 1, 0, 3, 0, 1, 1);
        add(0, 0, 1, 0, 2, 0, 1, 1);
        add(0, 0, 1, 0, 1, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        // Push into empty: visible after one cycle
        add(1, 8, 0, 0, 1, 8, 1, 1);
        add(0, 0, 1, 0, 0, 8, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_data", int'(out_data), 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].iv, tbl[i].w, tbl[i].rdy, tbl[i].cl);
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].ecnt);
            chk($sformatf("v%0d_acc", i), int'(acc), tbl[i].eacc);
            chk($sformatf("v%0d_ovf", i), int'(overflow), int'(tbl[i].eovf));
            chk($sformatf("v%0d_valid", i), int'(out_valid), int'(tbl[i].evld));
        end

        // Accumulator wrap through steady push+pop
        cyc(1'b0, 5'd0, 1'b0, 1'b1);
        chk("clr_acc", int'(acc), 0);
        chk("clr_ovf", int'(overflow), 0);
        for (int i = 0; i < 133; i++) cyc(1'b1, 5'd31, 1'b1, 1'b0);
        exp_acc = (133 * 31) % (1 << ACC_W);
        chk("wrap_acc", int'(acc), exp_acc);
        chk("wrap_count", int'(count), 1);

        // Reset mid-stream with 3 entries queued; inputs active on the reset edge
        cyc(1'b1, 5'd2, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 1'b0, 1'b0);
        chk("pre_rst_count", int'(count), 3);
        rstn = 1'b0; in_valid = 1'b1; {co, s} = 5'd4; out_ready = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_acc", int'(acc), 0);
        chk("mid_rst_data", int'(out_data), 0);
        rstn = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", int'(out_valid), 0);
        chk("post_rst_count", int'(count), 0);
        cyc(1'b1, 5'd19, 1'b0, 1'b0);
        chk("post_rst_acc", int'(acc), 19);
        cyc(1'b0, 5'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
